// File: rtl/mlp_seq_infer.sv
// mlp_seq_infer: sequential two-layer perceptron inference engine.
// One shared signed MAC performs one multiply-accumulate per cycle.
// The hidden layer applies ReLU and clamps each activation to [0, MAX].
// The output layer is linear and saturates each result to the word range.
// Ports:
//   clk, reset_n                 : clock (rising edge); async active-low reset
//   weights_en/data/ready        : weight word stream, accepted only in IDLE
//   weights_loaded               : a complete weight set is resident
//   in_en/in_data/in_ready       : input vector, element k at [k*W +: W]
//   out_en/out_data              : one-cycle result strobe and result vector
module mlp_seq_infer #(
  parameter int WORD_BITS = 8,
  parameter int N_IN      = 2,
  parameter int N_HID     = 2,
  parameter int N_OUT     = 1,
  parameter int ACC_BITS  = 20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       weights_en,
  input  logic [WORD_BITS-1:0]       weights_data,
  output logic                       weights_ready,
  output logic                       weights_loaded,
  input  logic                       in_en,
  input  logic [N_IN*WORD_BITS-1:0]  in_data,
  output logic                       in_ready,
  output logic                       out_en,
  output logic [N_OUT*WORD_BITS-1:0] out_data
);

  localparam int NW   = (N_IN + 1) * N_HID + (N_HID + 1) * N_OUT;
  localparam int PW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int JMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int JW   = $clog2(JMAX + 1);
  localparam int PEXT = ACC_BITS - 2 * WORD_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L1   = 2'd1;
  localparam logic [1:0] S_L2   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [ACC_BITS-1:0] MAX_V = ACC_BITS'((2 ** (WORD_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] MIN_V = -ACC_BITS'(2 ** (WORD_BITS - 1));

  logic [1:0]                       state;
  logic [PW-1:0]                    ptr;
  logic [PW-1:0]                    maddr;
  logic [KW-1:0]                    k;
  logic [JW-1:0]                    j;
  logic signed [ACC_BITS-1:0]       acc;
  logic [N_IN*WORD_BITS-1:0]        x_reg;
  logic [N_HID*WORD_BITS-1:0]       h_reg;
  logic [N_OUT*WORD_BITS-1:0]       y_reg;
  logic [WORD_BITS-1:0]             wmem [NW];

  logic                             accept;
  logic                             wr;
  logic [KW-1:0]                    k_last;
  logic [JW-1:0]                    j_last;
  logic [KW-1:0]                    ksel;
  logic [WORD_BITS-1:0]             w_cur;
  logic [WORD_BITS-1:0]             opnd;
  logic signed [2*WORD_BITS-1:0]    a_ext;
  logic signed [2*WORD_BITS-1:0]    b_ext;
  logic signed [2*WORD_BITS-1:0]    prod;
  logic signed [ACC_BITS-1:0]       sum;
  logic [WORD_BITS-1:0]             relu_val;
  logic [WORD_BITS-1:0]             sat_val;

  assign weights_ready = (state == S_IDLE);
  assign in_ready      = (state == S_IDLE) && weights_loaded;
  assign accept        = in_en && in_ready;
  // An input vector wins over a simultaneous weight word; the word is dropped.
  assign wr            = weights_en && weights_ready && !accept;

  always_comb begin
    k_last = (state == S_L1) ? KW'(N_IN) : KW'(N_HID);
    j_last = (state == S_L1) ? JW'(N_HID - 1) : JW'(N_OUT - 1);
    ksel   = (k == '0) ? '0 : k - 1'b1;
    if (k == '0)
      opnd = WORD_BITS'(1);
    else if (state == S_L1)
      opnd = x_reg[ksel*WORD_BITS +: WORD_BITS];
    else
      opnd = h_reg[ksel*WORD_BITS +: WORD_BITS];
    w_cur = wmem[maddr];
    a_ext = {{WORD_BITS{w_cur[WORD_BITS-1]}}, w_cur};
    b_ext = {{WORD_BITS{opnd[WORD_BITS-1]}}, opnd};
    prod  = a_ext * b_ext;
    sum   = acc + {{PEXT{prod[2*WORD_BITS-1]}}, prod};
    if (sum < 0)
      relu_val = '0;
    else if (sum > MAX_V)
      relu_val = MAX_V[WORD_BITS-1:0];
    else
      relu_val = sum[WORD_BITS-1:0];
    if (sum < MIN_V)
      sat_val = MIN_V[WORD_BITS-1:0];
    else if (sum > MAX_V)
      sat_val = MAX_V[WORD_BITS-1:0];
    else
      sat_val = sum[WORD_BITS-1:0];
  end

  // Weight storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr)
      wmem[ptr] <= weights_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr            <= '0;
      weights_loaded <= 1'b0;
    end else if (wr) begin
      if (ptr == PW'(NW - 1)) begin
        ptr            <= '0;
        weights_loaded <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
        if (ptr == '0)
          weights_loaded <= 1'b0;
      end
    end
  end

  // Weights are stored in exactly the order the MACs consume them, so the
  // read address is a plain counter over the whole inference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      maddr    <= '0;
      k        <= '0;
      j        <= '0;
      acc      <= '0;
      x_reg    <= '0;
      h_reg    <= '0;
      y_reg    <= '0;
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      out_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_reg <= in_data;
            maddr <= '0;
            k     <= '0;
            j     <= '0;
            acc   <= '0;
            state <= S_L1;
          end
        end
        S_L1, S_L2: begin
          maddr <= maddr + 1'b1;
          if (k == k_last) begin
            acc <= '0;
            k   <= '0;
            if (state == S_L1)
              h_reg[j*WORD_BITS +: WORD_BITS] <= relu_val;
            else
              y_reg[j*WORD_BITS +: WORD_BITS] <= sat_val;
            if (j == j_last) begin
              j     <= '0;
              state <= (state == S_L1) ? S_L2 : S_DONE;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        default: begin
          out_data <= y_reg;
          out_en   <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mlp_seq_infer.md
Name: mlp_seq_infer

Overview:
- Parametrised, fully sequential two-layer perceptron inference engine.
- Signed fixed-point inputs pass through a hidden layer with ReLU, then a linear output layer.
- Weights are runtime-loadable over a word stream; one shared multiplier-accumulator does one MAC per cycle.
- Sits between the sample front-end (in_* stream) and downstream classification logic (out_* stream).

Parameters:
- WORD_BITS, 8: width of every weight, input, hidden activation and output word (signed two's complement).
- N_IN, 2: input vector length.
- N_HID, 2: hidden neurons.
- N_OUT, 1: output neurons.
- ACC_BITS, 20: accumulator width (signed); must be at least 2*WORD_BITS + clog2(max(N_IN, N_HID) + 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- weights_en  in  1  weight word valid.
- weights_data  in  WORD_BITS  signed weight word.
- weights_ready  out  1  high when state is IDLE; weight words are written only when weights_en & weights_ready.
- weights_loaded  out  1  a complete weight set is resident.
- in_en  in  1  input vector valid.
- in_data  in  N_IN*WORD_BITS  input vector; element k occupies bits [k*WORD_BITS +: WORD_BITS].
- in_ready  out  1  high when state is IDLE and weights_loaded.
- out_en  out  1  single-cycle result strobe.
- out_data  out  N_OUT*WORD_BITS  result vector, same packing as in_data.

Behaviour:
- Reset (async assert, sync release): state IDLE, weight pointer 0, weights_loaded 0, out_en 0, out_data 0, accumulator 0. weights_ready is 1 during reset; in_ready is 0.
- Weight storage: NW = (N_IN+1)*N_HID + (N_HID+1)*N_OUT words.
- Weight load order, layer 1: for each hidden neuron j = 0..N_HID-1, bias first, then the weights for x0..x(N_IN-1).
- Weight load order, layer 2: for each output neuron i = 0..N_OUT-1, bias first, then the weights for h0..h(N_HID-1).
- Weight pointer: advances by 1 per accepted word. Writing index NW-1 sets weights_loaded and wraps the pointer to 0.
- Reload: an accepted word at pointer 0 while weights_loaded=1 clears weights_loaded. The set becomes usable again only after all NW words are written.
- Weights are not reset; only the pointer and the loaded flag are.
- FSM states: IDLE, L1, L2, DONE.
- IDLE -> L1 when in_en & in_ready. in_data is captured into an internal register on that edge; in_data may change afterwards.
- L1: one MAC per cycle over (bias*1, x0..x(N_IN-1)) per hidden neuron, N_HID*(N_IN+1) cycles.
- End of each hidden neuron: ReLU, then clamp to [0, 2^(WORD_BITS-1)-1], store to h[j].
- L2: one MAC per cycle over (bias*1, h0..h(N_HID-1)) per output neuron, N_OUT*(N_HID+1) cycles.
- End of each output neuron: saturate to [-2^(WORD_BITS-1), 2^(WORD_BITS-1)-1], no activation.
- DONE: out_en=1 and out_data valid for exactly one cycle, then IDLE. out_data holds its value until the next DONE.
- Latency: out_en is high at edge L = N_HID*(N_IN+1) + N_OUT*(N_HID+1) + 1 after the accepting edge. Defaults give L = 10.
- Throughput: one vector per L+1 cycles.
- Arithmetic: products are full 2*WORD_BITS signed and sign-extended to ACC_BITS. The accumulator does not wrap within the legal ACC_BITS range.
- Simultaneous in_en and weights_en in IDLE with in_ready=1: the input is accepted, the weight word is dropped, and the pointer is unchanged.
- weights_en outside IDLE: ignored. in_en when in_ready=0: ignored, no queueing.
- Reset mid-computation: the computation is aborted with no out_en pulse. A new weight load is required before in_ready rises.

Test Plan:
- XOR load: load 0,1,1, -1,1,1, 0,1,-2 (NW=9) -> weights_loaded=1 after the 9th word, in_ready=1. Inputs (0,0)/(0,1)/(1,0)/(1,1) -> out_data 0/1/1/0, each with out_en exactly 10 cycles after acceptance.
- Saturation: all weights 127, inputs (127,127) -> hidden neurons clamp to 127, output clamps to 127. Output bias -128 with other weights -128 and inputs 127 -> output -128. Hidden pre-activation negative -> h=0.
- Partial load: write 5 of 9 words -> weights_loaded=0, in_ready=0, in_en ignored with no out_en. Complete the remaining 4 -> in_ready=1.
- Collision: in_en and weights_en high together in IDLE -> vector processed correctly. Next weight word lands at the unchanged pointer, verified by a reload and an XOR recheck.
- Reset mid-L1 (cycle 3): assert reset_n=0 -> out_en never pulses, weights_loaded=0, weights_ready=1. After release, reload and rerun the XOR vectors -> correct results.
- Back-to-back: hold in_en high over 4 vectors -> acceptances exactly 11 cycles apart, and in_ready=0 during L1/L2/DONE.
